// File: rtl/sudoku_pkg.sv
// Shared types and default sizing for the tile-grid solve path.
package sudoku_pkg;

    // Default grid sizing; instances may override GRID_ORD and derive their own.
    localparam int DEF_GRID_ORD = 3;
    localparam int DEF_LEN      = DEF_GRID_ORD * DEF_GRID_ORD;
    localparam int DEF_AREA     = DEF_LEN * DEF_LEN;
    localparam int DEF_AREA_W   = $clog2(DEF_AREA);
    localparam int DEF_VAL_W    = (DEF_LEN > 1) ? $clog2(DEF_LEN) : 1;

    // Width of a binary tile value for a given LEN, never narrower than one bit.
    function automatic int val_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    typedef enum logic [1:0] {
        RC_NONE    = 2'b00,
        RC_SUCCESS = 2'b01,
        RC_NOSOLN  = 2'b10,
        RC_TIMEOUT = 2'b11
    } result_code_t;

    // One-hot sequencer state codes.
    localparam logic [5:0] ST_IDLE   = 6'b000001;
    localparam logic [5:0] ST_CLR    = 6'b000010;
    localparam logic [5:0] ST_ARM    = 6'b000100;
    localparam logic [5:0] ST_WAIT   = 6'b001000;
    localparam logic [5:0] ST_STREAM = 6'b010000;
    localparam logic [5:0] ST_REPORT = 6'b100000;

    typedef enum logic [5:0] {
        S_IDLE   = ST_IDLE,
        S_CLR    = ST_CLR,
        S_ARM    = ST_ARM,
        S_WAIT   = ST_WAIT,
        S_STREAM = ST_STREAM,
        S_REPORT = ST_REPORT
    } seq_state_t;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary index encoder; lowest set bit wins, all-zero maps to 0.
module onehot_to_bin #(
    parameter int LEN   = 9,
    parameter int VAL_W = 4
) (
    input  logic [LEN-1:0]   onehot,
    output logic [VAL_W-1:0] index,
    output logic             is_onehot
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        for (int i = LEN - 1; i >= 0; i--) begin
            if (onehot[i]) begin
                index = VAL_W'(i);
            end
        end
        is_onehot = (onehot != '0) && ((onehot & (onehot - LEN'(1))) == '0);
    end

endmodule

// File: rtl/grid_solve_sequencer.sv
// Runs one grid solve per request: clear, start, watch done under a watchdog,
// then stream the solved tiles out in row-major order as binary digits.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// CLR    | one-cycle grid_reset pulse
// ARM    | one-cycle grid_start pulse
// WAIT   | counting cycles until done/success or watchdog expiry
// STREAM | presenting tile rd_addr on the output handshake
// REPORT | one-cycle result_valid pulse
module grid_solve_sequencer
    import sudoku_pkg::*;
#(
    parameter int GRID_ORD       = DEF_GRID_ORD,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
    localparam int LEN           = GRID_ORD * GRID_ORD,
    localparam int AREA          = LEN * LEN,
    localparam int AREA_W        = $clog2(AREA),
    localparam int VAL_W         = val_width(LEN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    output logic              grid_reset,
    output logic              grid_start,
    input  logic              grid_done,
    input  logic              grid_success,
    output logic [AREA_W-1:0] rd_addr,
    input  logic [LEN-1:0]    rd_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [VAL_W-1:0]  out_data,
    output logic              out_last,
    output logic              result_valid,
    output logic [1:0]        result_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              onehot_err
);

    seq_state_t        state_q, state_d;
    logic [AREA_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    result_code_t      result_code_q, result_code_d;
    logic              onehot_err_q, onehot_err_d;

    logic [VAL_W-1:0]  enc_index;
    logic              enc_is_onehot;
    logic              streaming;
    logic              at_last;

    onehot_to_bin #(
        .LEN   (LEN),
        .VAL_W (VAL_W)
    ) u_enc (
        .onehot    (rd_value),
        .index     (enc_index),
        .is_onehot (enc_is_onehot)
    );

    assign streaming = (state_q == S_STREAM);
    assign at_last   = (rd_addr_q == AREA_W'(AREA - 1));

    // Next-state, address, watchdog and result bookkeeping.
    always_comb begin
        state_d       = state_q;
        rd_addr_d     = rd_addr_q;
        cycle_count_d = cycle_count_q;
        result_code_d = result_code_q;
        onehot_err_d  = onehot_err_q;

        case (state_q)
            S_IDLE: begin
                rd_addr_d = '0;
                if (req_valid) begin
                    state_d       = S_CLR;
                    cycle_count_d = '0;
                    onehot_err_d  = 1'b0;
                    result_code_d = RC_NONE;
                end
            end
            S_CLR: begin
                state_d = S_ARM;
            end
            S_ARM: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Every WAIT cycle is counted, including the one that ends the wait.
                if (cycle_count_q != CNT_W'(TIMEOUT_CYCLES)) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
                if (grid_done && grid_success) begin
                    state_d = S_STREAM;
                end else if (grid_done) begin
                    state_d       = S_REPORT;
                    result_code_d = RC_NOSOLN;
                end else if (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = S_REPORT;
                    result_code_d = RC_TIMEOUT;
                end
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (!enc_is_onehot) begin
                        onehot_err_d = 1'b1;
                    end
                    if (at_last) begin
                        state_d       = S_REPORT;
                        result_code_d = RC_SUCCESS;
                    end else begin
                        rd_addr_d = rd_addr_q + AREA_W'(1);
                    end
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers; reset never pulses the grid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rd_addr_q     <= '0;
            cycle_count_q <= '0;
            result_code_q <= RC_NONE;
            onehot_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_addr_q     <= rd_addr_d;
            cycle_count_q <= cycle_count_d;
            result_code_q <= result_code_d;
            onehot_err_q  <= onehot_err_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign grid_reset   = (state_q == S_CLR);
    assign grid_start   = (state_q == S_ARM);
    assign result_valid = (state_q == S_REPORT);
    assign out_valid    = streaming;
    assign out_data     = streaming ? enc_index : '0;
    assign out_last     = streaming && at_last;
    assign rd_addr      = rd_addr_q;
    assign result_code  = result_code_q;
    assign cycle_count  = cycle_count_q;
    assign onehot_err   = onehot_err_q;

endmodule

// File: tb/tb_grid_solve_sequencer.sv
// Directed bench for grid_solve_sequencer at GRID_ORD=2, TIMEOUT_CYCLES=8.
module tb_grid_solve_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       grid_reset;
    logic       grid_start;
    logic       grid_done = 1'b0;
    logic       grid_success = 1'b0;
    logic [3:0] rd_addr;
    logic [3:0] rd_value;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_data;
    logic       out_last;
    logic       result_valid;
    logic [1:0] result_code;
    logic [3:0] cycle_count;
    logic       onehot_err;

    logic       bad_mode = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [1:0] obs_data [16];
    logic       obs_last [16];
    logic       obs_err  [16];

    grid_solve_sequencer #(
        .GRID_ORD       (2),
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .grid_reset   (grid_reset),
        .grid_start   (grid_start),
        .grid_done    (grid_done),
        .grid_success (grid_success),
        .rd_addr      (rd_addr),
        .rd_value     (rd_value),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .result_valid (result_valid),
        .result_code  (result_code),
        .cycle_count  (cycle_count),
        .onehot_err   (onehot_err)
    );

    always #5 clock = ~clock;

    // Grid read port model: tile value is 1 << (addr % 4), with an optional bad tile at 5.
    always_comb begin
        rd_value = 4'b0001 << rd_addr[1:0];
        if (bad_mode && rd_addr == 4'd5) rd_value = 4'b0110;
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // From IDLE: request accepted, then CLR, ARM, land in WAIT cycle 1.
    task automatic launch();
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
    endtask

    // From WAIT cycle 1: raise done on WAIT cycle k.
    task automatic finish_wait(input int k, input logic succ);
        repeat (k - 1) step();
        grid_done = 1'b1;
        grid_success = succ;
        step();
        grid_done = 1'b0;
        grid_success = 1'b0;
    endtask

    // Records handshaken words until back in IDLE (or stop_at words seen).
    task automatic stream_run(input bit toggle, input int stop_at, output int words,
                              output int stall_bad, output int pulses, output bit finished);
        logic [3:0] pat;
        logic       prev_v, prev_r;
        logic [1:0] prev_d;
        logic [3:0] prev_a;
        pat = 4'b1001;
        words = 0; stall_bad = 0; pulses = 0; finished = 1'b0;
        prev_v = 1'b0; prev_r = 1'b0; prev_d = '0; prev_a = '0;
        for (int c = 0; c < 200; c++) begin
            if (stop_at >= 0 && words == stop_at) begin
                finished = 1'b1;
                return;
            end
            out_ready = toggle ? pat[c % 4] : 1'b1;
            if (prev_v && !prev_r && out_valid && (out_data !== prev_d || rd_addr !== prev_a))
                stall_bad++;
            if (out_valid && out_ready) begin
                if (words < 16) begin
                    obs_data[words] = out_data;
                    obs_last[words] = out_last;
                    obs_err[words]  = onehot_err;
                end
                words++;
            end
            if (result_valid) pulses++;
            if (c > 0 && req_ready) begin
                finished = 1'b1;
                out_ready = 1'b0;
                return;
            end
            prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_a = rd_addr;
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if ({out_valid, grid_reset, grid_start, result_valid} !== 4'b0000) begin n_bad++; $display("FAIL reset_pulses: got %b want 0000", {out_valid, grid_reset, grid_start, result_valid}); end
        n_cmp++; if ({result_code, cycle_count, onehot_err, rd_addr} !== 11'd0) begin n_bad++; $display("FAIL reset_regs: code %0d cnt %0d err %b addr %0d want all 0", result_code, cycle_count, onehot_err, rd_addr); end
    endtask

    task automatic test_success_stream();
        int w, sb, p;
        bit fin;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n_cmp++; if ({grid_reset, grid_start, req_ready} !== 3'b100) begin n_bad++; $display("FAIL clr_outputs: got %b want 100", {grid_reset, grid_start, req_ready}); end
        step();
        n_cmp++; if ({grid_reset, grid_start} !== 2'b01) begin n_bad++; $display("FAIL arm_outputs: got %b want 01", {grid_reset, grid_start}); end
        step();
        finish_wait(3, 1'b1);
        n_cmp++; if (out_valid !== 1'b1 || rd_addr !== 4'd0) begin n_bad++; $display("FAIL first_word: valid %b addr %0d want 1 0", out_valid, rd_addr); end
        stream_run(1'b0, -1, w, sb, p, fin);
        n_cmp++; if (fin !== 1'b1 || w !== 16) begin n_bad++; $display("FAIL words_ready: got %0d fin %b want 16", w, fin); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (obs_data[i] !== 2'(i % 4) || obs_last[i] !== (i == 15)) begin n_bad++; $display("FAIL word_%0d: data %0d last %b want %0d %b", i, obs_data[i], obs_last[i], i % 4, i == 15); end
        end
        n_cmp++; if (p !== 1) begin n_bad++; $display("FAIL result_pulses: got %0d want 1", p); end
        n_cmp++; if (result_code !== 2'b01 || cycle_count !== 4'd3) begin n_bad++; $display("FAIL success_result: code %0d cnt %0d want 1 3", result_code, cycle_count); end
    endtask

    task automatic test_backpressure();
        int w, sb, p;
        bit fin;
        launch();
        finish_wait(3, 1'b1);
        stream_run(1'b1, -1, w, sb, p, fin);
        n_cmp++; if (fin !== 1'b1 || w !== 16) begin n_bad++; $display("FAIL words_bp: got %0d fin %b want 16", w, fin); end
        n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", sb); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (obs_data[i] !== 2'(i % 4)) begin n_bad++; $display("FAIL bp_word_%0d: got %0d want %0d", i, obs_data[i], i % 4); end
        end
        n_cmp++; if (result_code !== 2'b01 || p !== 1) begin n_bad++; $display("FAIL bp_result: code %0d pulses %0d want 1 1", result_code, p); end
    endtask

    task automatic test_no_solution();
        bit seen_v;
        seen_v = 1'b0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n_cmp++; if (cycle_count !== 4'd0 || result_code !== 2'b00) begin n_bad++; $display("FAIL accept_clears: cnt %0d code %0d want 0 0", cycle_count, result_code); end
        step();
        step();
        req_valid = 1'b1;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready: got %b want 0", req_ready); end
        repeat (4) begin step(); if (out_valid) seen_v = 1'b1; end
        grid_done = 1'b1;
        step();
        grid_done = 1'b0;
        req_valid = 1'b0;
        n_cmp++; if (result_valid !== 1'b1 || result_code !== 2'b10 || cycle_count !== 4'd5 || seen_v || out_valid) begin n_bad++; $display("FAIL nosoln_result: rv %b code %0d cnt %0d valid %b want 1 2 5 0", result_valid, result_code, cycle_count, seen_v | out_valid); end
        step();
        n_cmp++; if (result_valid !== 1'b0 || req_ready !== 1'b1 || result_code !== 2'b10) begin n_bad++; $display("FAIL nosoln_hold: rv %b rdy %b code %0d want 0 1 2", result_valid, req_ready, result_code); end
    endtask

    task automatic test_timeout();
        int steps;
        steps = 0;
        launch();
        while (!result_valid && steps < 30) begin
            step();
            steps++;
        end
        n_cmp++; if (steps !== 8) begin n_bad++; $display("FAIL timeout_cycles: got %0d want 8", steps); end
        n_cmp++; if (result_code !== 2'b11 || cycle_count !== 4'd8) begin n_bad++; $display("FAIL timeout_result: code %0d cnt %0d want 3 8", result_code, cycle_count); end
        step();
        launch();
        finish_wait(8, 1'b0);
        n_cmp++; if (result_valid !== 1'b1 || result_code !== 2'b10 || cycle_count !== 4'd8) begin n_bad++; $display("FAIL done_beats_timeout: rv %b code %0d cnt %0d want 1 2 8", result_valid, result_code, cycle_count); end
        step();
    endtask

    task automatic test_onehot_err();
        int w, sb, p;
        bit fin;
        bad_mode = 1'b1;
        launch();
        finish_wait(2, 1'b1);
        stream_run(1'b0, -1, w, sb, p, fin);
        bad_mode = 1'b0;
        n_cmp++; if (fin !== 1'b1 || w !== 16 || obs_data[5] !== 2'd1) begin n_bad++; $display("FAIL bad_tile_data: words %0d data %0d want 16 1", w, obs_data[5]); end
        n_cmp++; if (obs_err[5] !== 1'b0 || obs_err[6] !== 1'b1) begin n_bad++; $display("FAIL err_rise: at5 %b at6 %b want 0 1", obs_err[5], obs_err[6]); end
        n_cmp++; if (onehot_err !== 1'b1 || cycle_count !== 4'd2) begin n_bad++; $display("FAIL err_sticky: err %b cnt %0d want 1 2", onehot_err, cycle_count); end
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        n_cmp++; if (onehot_err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", onehot_err); end
        step();
        step();
        finish_wait(1, 1'b0);
        step();
    endtask

    task automatic test_reset_mid_stream();
        int w, sb, p;
        bit fin;
        launch();
        finish_wait(3, 1'b1);
        stream_run(1'b0, 7, w, sb, p, fin);
        n_cmp++; if (fin !== 1'b1 || rd_addr !== 4'd7 || out_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset: addr %0d valid %b want 7 1", rd_addr, out_valid); end
        out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || req_ready !== 1'b1 || result_code !== 2'b00 || rd_addr !== 4'd0 || grid_reset !== 1'b0) begin n_bad++; $display("FAIL async_reset: valid %b rdy %b code %0d addr %0d want 0 1 0 0", out_valid, req_ready, result_code, rd_addr); end
        step();
        reset = 1'b0;
        step();
        launch();
        finish_wait(4, 1'b1);
        n_cmp++; if (rd_addr !== 4'd0) begin n_bad++; $display("FAIL rerun_addr: got %0d want 0", rd_addr); end
        stream_run(1'b0, -1, w, sb, p, fin);
        n_cmp++; if (fin !== 1'b1 || w !== 16 || obs_data[7] !== 2'd3 || obs_last[15] !== 1'b1) begin n_bad++; $display("FAIL rerun: words %0d d7 %0d last %b want 16 3 1", w, obs_data[7], obs_last[15]); end
        n_cmp++; if (result_code !== 2'b01 || cycle_count !== 4'd4) begin n_bad++; $display("FAIL rerun_result: code %0d cnt %0d want 1 4", result_code, cycle_count); end
    endtask

    initial begin
        step();
        test_reset();
        reset = 1'b0;
        step();
        test_reset();
        test_success_stream();
        test_backpressure();
        test_no_solution();
        test_timeout();
        test_onehot_err();
        test_reset_mid_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
